// File: rtl/regfile_scoreboard.sv
// ==== regfile_scoreboard : multi-port integer register file with busy-bit scoreboard -- rev 1.0 ====
`default_nettype none

module regfile_scoreboard #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int NRP        = 2,
  parameter int NWP        = 1,
  parameter int SYNC_READ  = 1,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRP-1:0]        rd_en,
  input  logic [NRP*AW-1:0]     rd_addr,
  output logic [NRP*XLEN-1:0]   rd_data,
  output logic [NRP-1:0]        rd_busy,
  output logic                  hazard,
  input  logic [NWP-1:0]        wr_en,
  input  logic [NWP*AW-1:0]     wr_addr,
  input  logic [NWP*XLEN-1:0]   wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [(2**AW)-1:0]    busy_vec
);

  localparam int   C_DEPTH = 2**AW;
  localparam logic C_BYP   = (BYPASS != 0);
  localparam logic C_INIT  = (INIT_INDEX != 0);

  logic [XLEN-1:0]    rf_q [C_DEPTH];
  logic [XLEN-1:0]    rf_d [C_DEPTH];
  logic [C_DEPTH-1:0] busy_q;
  logic [C_DEPTH-1:0] busy_d;
  logic [NRP*XLEN-1:0] rd_val;

  // Ascending port order makes the highest-index writer win on a collision.
  always_comb begin
    rf_d = rf_q;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en[w]) begin
        rf_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
    end
    if (rst) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        rf_d[i] = C_INIT ? XLEN'(i) : '0;
      end
    end
    rf_d[0] = '0;
  end

  // Issue is applied after the write clear so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWP; w++) begin
      if (wr_en[w]) begin
        busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (rst) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    rf_q   <= rf_d;
    busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  generate
    for (genvar p = 0; p < NRP; p++) begin : g_rport
      logic [AW-1:0]   ra;
      logic            hit;
      logic [XLEN-1:0] fwd;

      assign ra = rd_addr[p*AW +: AW];

      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int w = 0; w < NWP; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == ra) && (ra != '0)) begin
            hit = 1'b1;
            fwd = wr_data[w*XLEN +: XLEN];
          end
        end
      end

      assign rd_val[p*XLEN +: XLEN] = (C_BYP && hit) ? fwd : rf_q[ra];
      // A bypassed write clears the busy view in the same cycle, so no stall.
      assign rd_busy[p] = busy_q[ra] & ~(C_BYP & hit);
    end
  endgenerate

  assign hazard = |(rd_en & rd_busy);

  generate
    if (SYNC_READ != 0) begin : g_sync_read
      logic [NRP*XLEN-1:0] rd_data_q;
      logic [NRP*XLEN-1:0] rd_data_d;

      always_comb begin
        rd_data_d = rst ? '0 : rd_val;
      end

      always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
      end

      assign rd_data = rd_data_q;
    end else begin : g_comb_read
      assign rd_data = rd_val;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ==== tb_regfile_scoreboard : directed self-checking bench for regfile_scoreboard -- rev 1.0 ====
`default_nettype none

module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_a, rd_data_b, rd_data_c;
  logic [1:0]  rd_busy_a, rd_busy_b, rd_busy_c;
  logic        hazard_a, hazard_b, hazard_c;
  logic [31:0] busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  // A: sync read + bypass, B: sync read without bypass, C: comb read, zero init.
  regfile_scoreboard #(.NWP(2), .SYNC_READ(1), .BYPASS(1), .INIT_INDEX(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .hazard(hazard_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_a));

  regfile_scoreboard #(.NWP(2), .SYNC_READ(1), .BYPASS(0), .INIT_INDEX(1)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .hazard(hazard_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_b));

  regfile_scoreboard #(.NWP(2), .SYNC_READ(0), .BYPASS(1), .INIT_INDEX(0)) dut_c (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .rd_busy(rd_busy_c), .hazard(hazard_c), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
    rd_en  = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rd_addr = {5'd31, 5'd5};
    tick();
    checks++; if (rd_data_a[31:0] !== 32'd0) begin errors++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data_a[31:0], 32'd0); end
    rst = 1'b0;
    tick();
    checks++; if (rd_data_a[31:0] !== 32'd5) begin errors++; $display("FAIL init_x5_a got=%h exp=%h", rd_data_a[31:0], 32'd5); end
    checks++; if (rd_data_a[63:32] !== 32'd31) begin errors++; $display("FAIL init_x31_a got=%h exp=%h", rd_data_a[63:32], 32'd31); end
    checks++; if (rd_data_b[31:0] !== 32'd5) begin errors++; $display("FAIL init_x5_b got=%h exp=%h", rd_data_b[31:0], 32'd5); end
    checks++; if (rd_data_c[31:0] !== 32'd0) begin errors++; $display("FAIL init_zero_c got=%h exp=%h", rd_data_c[31:0], 32'd0); end
    checks++; if (busy_a !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=%h", busy_a, 32'd0); end
    rd_en = 2'b11;
    #1;
    checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=%b", hazard_a, 1'b0); end
    idle();
  endtask

  task automatic test_bypass();
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd7};
    wr_data = {32'd0, 32'hDEADBEEF};
    rd_addr = {5'd0, 5'd7};
    #1;
    checks++; if (rd_data_c[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL comb_bypass got=%h exp=%h", rd_data_c[31:0], 32'hDEADBEEF); end
    tick();
    wr_en = 2'b00;
    checks++; if (rd_data_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sync_bypass_a got=%h exp=%h", rd_data_a[31:0], 32'hDEADBEEF); end
    checks++; if (rd_data_b[31:0] !== 32'd7) begin errors++; $display("FAIL nobypass_old_b got=%h exp=%h", rd_data_b[31:0], 32'd7); end
    tick();
    checks++; if (rd_data_b[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL nobypass_reread_b got=%h exp=%h", rd_data_b[31:0], 32'hDEADBEEF); end
  endtask

  task automatic test_zero_reg();
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd0};
    wr_data  = {32'd0, 32'h1234};
    iss_en   = 1'b1;
    iss_addr = 5'd0;
    rd_en    = 2'b01;
    rd_addr  = {5'd0, 5'd0};
    #1;
    checks++; if (rd_data_c[31:0] !== 32'd0) begin errors++; $display("FAIL x0_comb got=%h exp=%h", rd_data_c[31:0], 32'd0); end
    tick();
    idle();
    rd_en = 2'b01;
    #1;
    checks++; if (rd_data_a[31:0] !== 32'd0) begin errors++; $display("FAIL x0_read got=%h exp=%h", rd_data_a[31:0], 32'd0); end
    checks++; if (busy_a !== 32'd0) begin errors++; $display("FAIL x0_busy got=%h exp=%h", busy_a, 32'd0); end
    checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL x0_hazard got=%b exp=%b", hazard_a, 1'b0); end
    idle();
  endtask

  task automatic test_dual_write();
    wr_en   = 2'b11;
    wr_addr = {5'd9, 5'd9};
    wr_data = {32'h22, 32'h11};
    rd_addr = {5'd0, 5'd9};
    #1;
    checks++; if (rd_data_c[31:0] !== 32'h22) begin errors++; $display("FAIL dual_comb got=%h exp=%h", rd_data_c[31:0], 32'h22); end
    tick();
    wr_en = 2'b00;
    checks++; if (rd_data_a[31:0] !== 32'h22) begin errors++; $display("FAIL dual_bypass_a got=%h exp=%h", rd_data_a[31:0], 32'h22); end
    checks++; if (rd_data_b[31:0] !== 32'd9) begin errors++; $display("FAIL dual_old_b got=%h exp=%h", rd_data_b[31:0], 32'd9); end
    tick();
    checks++; if (rd_data_b[31:0] !== 32'h22) begin errors++; $display("FAIL dual_stored_b got=%h exp=%h", rd_data_b[31:0], 32'h22); end
    checks++; if (rd_data_a[31:0] !== 32'h22) begin errors++; $display("FAIL dual_stored_a got=%h exp=%h", rd_data_a[31:0], 32'h22); end
  endtask

  task automatic test_scoreboard();
    iss_en   = 1'b1;
    iss_addr = 5'd3;
    tick();
    iss_en  = 1'b0;
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd3};
    #1;
    checks++; if (busy_a !== 32'h0000_0008) begin errors++; $display("FAIL issue_busy got=%h exp=%h", busy_a, 32'h8); end
    checks++; if (rd_busy_a !== 2'b01) begin errors++; $display("FAIL issue_rd_busy got=%b exp=%b", rd_busy_a, 2'b01); end
    checks++; if (hazard_a !== 1'b1) begin errors++; $display("FAIL issue_hazard got=%b exp=%b", hazard_a, 1'b1); end
    rd_en   = 2'b10;
    rd_addr = {5'd3, 5'd0};
    #1;
    checks++; if (hazard_a !== 1'b1) begin errors++; $display("FAIL port1_hazard got=%b exp=%b", hazard_a, 1'b1); end
    rd_en = 2'b00;
    #1;
    checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL unqualified_hazard got=%b exp=%b", hazard_a, 1'b0); end
    rd_en   = 2'b01;
    rd_addr = {5'd0, 5'd3};
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'd0, 32'h55};
    #1;
    checks++; if (rd_busy_a[0] !== 1'b0) begin errors++; $display("FAIL write_clear_rd_busy got=%b exp=%b", rd_busy_a[0], 1'b0); end
    checks++; if (hazard_a !== 1'b0) begin errors++; $display("FAIL write_clear_hazard got=%b exp=%b", hazard_a, 1'b0); end
    checks++; if (hazard_b !== 1'b1) begin errors++; $display("FAIL nobypass_hazard_b got=%b exp=%b", hazard_b, 1'b1); end
    tick();
    wr_en = 2'b00;
    checks++; if (busy_a !== 32'd0) begin errors++; $display("FAIL write_cleared got=%h exp=%h", busy_a, 32'd0); end
    checks++; if (rd_data_a[31:0] !== 32'h55) begin errors++; $display("FAIL write_data got=%h exp=%h", rd_data_a[31:0], 32'h55); end
    iss_en   = 1'b1;
    iss_addr = 5'd3;
    wr_en    = 2'b01;
    #1;
    checks++; if (rd_busy_a[0] !== 1'b0) begin errors++; $display("FAIL same_cycle_issue_rd_busy got=%b exp=%b", rd_busy_a[0], 1'b0); end
    tick();
    idle();
    checks++; if (busy_a !== 32'h0000_0008) begin errors++; $display("FAIL set_beats_clear got=%h exp=%h", busy_a, 32'h8); end
    checks++; if (busy_b !== 32'h0000_0008) begin errors++; $display("FAIL set_beats_clear_b got=%h exp=%h", busy_b, 32'h8); end
  endtask

  task automatic test_reset_mid();
    iss_en   = 1'b1;
    iss_addr = 5'd4;
    tick();
    iss_addr = 5'd6;
    tick();
    checks++; if (busy_a !== 32'h0000_0058) begin errors++; $display("FAIL pre_reset_busy got=%h exp=%h", busy_a, 32'h58); end
    rst      = 1'b1;
    iss_addr = 5'd8;
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd4};
    wr_data  = {32'd0, 32'h99};
    tick();
    rst = 1'b0;
    idle();
    rd_addr = {5'd0, 5'd4};
    checks++; if (busy_a !== 32'd0) begin errors++; $display("FAIL mid_reset_busy got=%h exp=%h", busy_a, 32'd0); end
    checks++; if (rd_data_c[31:0] !== 32'd0) begin errors++; $display("FAIL mid_reset_c got=%h exp=%h", rd_data_c[31:0], 32'd0); end
    tick();
    checks++; if (rd_data_a[31:0] !== 32'd4) begin errors++; $display("FAIL mid_reset_x4 got=%h exp=%h", rd_data_a[31:0], 32'd4); end
    iss_en   = 1'b1;
    iss_addr = 5'd10;
    tick();
    iss_en = 1'b0;
    checks++; if (busy_a !== 32'h0000_0400) begin errors++; $display("FAIL post_reset_issue got=%h exp=%h", busy_a, 32'h400); end
    wr_en   = 2'b10;
    wr_addr = {5'd10, 5'd0};
    wr_data = {32'h77, 32'd0};
    tick();
    wr_en = 2'b00;
    checks++; if (busy_a !== 32'd0) begin errors++; $display("FAIL post_reset_clear got=%h exp=%h", busy_a, 32'd0); end
  endtask

  initial begin
    rst      = 1'b1;
    rd_en    = '0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
    tick();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_dual_write();
    test_scoreboard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
